rf_wport_arbiter: RTL

//  Arbitrates the single GPR write port between the WB stage and the long-latency unit (LU).
//  The LU is the multi-cycle mul/div that writes GPRs. WB writes pass through with zero latency and always win.
//  LU results queue in a DEPTH-entry FIFO and drain into idle write slots.
//  A starvation counter can block the MEM->WB handoff to force a free slot.

---
 rtl/rf_wport_arbiter_if.sv | 36 +++
 rtl/rf_wport_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter_if.sv
// GPR write-port arbiter bus: WB request, LU result handshake,
// regfile write port and MEM-stage hold.
interface rf_wport_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wb_we;
    logic [4:0]    wb_waddr;
    logic [31:0]   wb_wdata;
    logic          lu_valid;
    logic          lu_ready;
    logic [4:0]    lu_waddr;
    logic [31:0]   lu_wdata;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          ms_block;
    logic [CW-1:0] lu_pending;

    modport master (
        output wb_we, wb_waddr, wb_wdata,
        output lu_valid, lu_waddr, lu_wdata,
        input  lu_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  ms_block, lu_pending
    );

    modport slave (
        input  wb_we, wb_waddr, wb_wdata,
        input  lu_valid, lu_waddr, lu_wdata,
        output lu_ready,
        output rf_we, rf_waddr, rf_wdata,
        output ms_block, lu_pending
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Single GPR write port shared by WB (always wins) and the LU
// result FIFO; a starvation counter forces a free slot via ms_block.
module rf_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input logic               clk,
    input logic               reset,
    rf_wport_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } lu_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FORCE
    } state_t;

    lu_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nx;
    state_t        state;
    state_t        state_nx;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          head_blocked;
    lu_entry_t     head;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign push         = bus.lu_valid && !full;
    assign pop          = !bus.wb_we && !empty;
    assign head_blocked = bus.wb_we && !empty;
    assign head         = mem[rd_ptr];

    assign bus.lu_ready   = !full;
    assign bus.lu_pending = count;
    assign bus.ms_block   = (state == FORCE);

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_nx = count;
        if (push && !pop) begin
            count_nx = count + CW'(1);
        end else if (!push && pop) begin
            count_nx = count - CW'(1);
        end
    end

    // FIFO storage; payload needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.lu_waddr, bus.lu_wdata};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nx;
        end
    end

    // Write-port mux: WB first, then the FIFO head
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        unique case (1'b1)
            bus.wb_we: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = bus.wb_waddr;
                bus.rf_wdata = bus.wb_wdata;
            end
            pop: begin
                bus.rf_we    = (head.waddr != 5'd0);
                bus.rf_waddr = head.waddr;
                bus.rf_wdata = head.wdata;
            end
            default: ;
        endcase
    end

    // State and starvation counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
        end
    end

    // Next state and saturating starvation count
    always_comb begin
        state_nx  = state;
        starve_nx = starve_cnt;
        unique case (state)
            IDLE: begin
                if (push) begin
                    state_nx  = WAIT;
                    starve_nx = '0;
                end
            end
            WAIT: begin
                if (pop) begin
                    starve_nx = '0;
                    if (count_nx == '0) state_nx = IDLE;
                end else if (head_blocked) begin
                    if (starve_cnt == SW'(STARVE_MAX - 1)) begin
                        state_nx = FORCE;
                    end
                    if (starve_cnt != SW'(STARVE_MAX)) begin
                        starve_nx = starve_cnt + SW'(1);
                    end
                end
            end
            FORCE: begin
                if (pop) begin
                    starve_nx = '0;
                    state_nx  = (count_nx == '0) ? IDLE : WAIT;
                end else if (starve_cnt != SW'(STARVE_MAX)) begin
                    starve_nx = starve_cnt + SW'(1);
                end
            end
            default: begin
                state_nx  = IDLE;
                starve_nx = '0;
            end
        endcase
    end
endmodule
